modport_bridge: RTL and testbench
=================================

// Module: modport_bridge
// PURPOSE
//  One-entry registered bridge between an upstream bus_if follower-side port and a
//  downstream bus_if master-side port (valid/ready, addr, data, write_enable).
//  Accepts one transfer upstream, holds it, and re-issues it downstream.
//  Keeps a transaction counter and last-write-data status for debug.
//  Sits between a bus master agent and a slave/peripheral.
// PARAMETERS
//  DATA_WIDTH  16  width of s_data/m_data (bus_if data_t)
//  ADDR_WIDTH  32  width of s_addr/m_addr (bus_if ADDR_WIDTH)
// PORTS
//  clk             in   1           clock; all state on posedge clk
//  rst             in   1           asynchronous, active-high reset
//  s_valid         in   1           upstream request valid
//  s_ready         out  1           upstream ready (bridge can accept)
//  s_addr          in   ADDR_WIDTH  upstream address
//  s_data          in   DATA_WIDTH  upstream data
//  s_write_enable  in   1           1 = write, 0 = read
//  m_valid         out  1           downstream request valid
//  m_ready         in   1           downstream ready
//  m_addr          out  ADDR_WIDTH  downstream address (registered)
//  m_data          out  DATA_WIDTH  downstream data (registered)
//  m_write_enable  out  1           downstream write enable (registered)
//  state           out  2           test_pkg::state_t: STATE_A / STATE_B / STATE_C
//  xfer_count      out  32          test_pkg::id_t, count of accepted upstream transfers
//  last_wdata      out  8           low byte of last accepted write data
// BEHAVIOUR
//  - Reset (async, rst=1), all registered outputs:
//    m_valid=0, m_write_enable=0, m_addr='0, m_data='0, state=STATE_A,
//    xfer_count='0, last_wdata='0.
//  - Handshake: a transfer completes at posedge clk when valid&&ready on that side.
//    Master side holds m_valid and all payload stable until m_ready.
//  - full == m_valid. s_ready = !full || m_ready. This is a combinational path
//    from m_ready to s_ready.
//  - Upstream accept (s_valid&&s_ready):
//    - load m_addr, m_data, m_write_enable from s_*; set m_valid=1 next cycle.
//    - xfer_count += 1, wraps at 2^32-1 -> 0.
//  - Write accept (s_write_enable=1): last_wdata <= s_data[7:0].
//  - Downstream complete (m_valid&&m_ready) with no accept: m_valid<=0.
//    Payload regs keep their last value.
//  - Simultaneous drain + accept: new payload loaded, m_valid stays 1.
//    Back-to-back throughput is 1 transfer/cycle.
//  - Latency: accepted at edge N -> m_valid visible after edge N, i.e. 1 cycle.
//  - State machine, updates with the buffer:
//    - STATE_A: empty.
//    - STATE_B: holding a write.
//    - STATE_C: holding a read.
//    - A->B/C on accept by write_enable. B/C->A on drain without accept.
//    - B/C->B/C per new write_enable on drain+accept.
//    - Unused encoding 2'b11 -> STATE_A (default branch).
//  - s_valid while full and !m_ready: not accepted (s_ready=0); upstream must hold.
//  - Reset mid-transfer: held transfer is discarded, no downstream completion.
// STRUCTURE
//  - test_pkg: WIDTH=32, id_t, state_t {STATE_A,STATE_B,STATE_C}.
//  - Sub-module: modport_hold_reg, a parameterised async-reset load-enable register
//    for the payload, instantiated once per field (addr, data, we).
//  - FSM, counter and handshake logic live in the top module.
// TESTING
//  1. Reset with rst=1 mid-run -> all outputs zero, state=STATE_A, s_ready=1.
//  2. Write: s_addr=32'h10, s_data=16'h1234, we=1, m_ready=0 ->
//     - next cycle m_valid=1, m_addr=32'h10, m_data=16'h1234, state=STATE_B,
//       last_wdata=8'h34, xfer_count=1.
//     - payload held while m_ready=0.
//  3. Backpressure: m_ready=0, full, second s_valid ->
//     - s_ready=0, no count change.
//     - raise m_ready -> second transfer accepted same edge, m_valid stays 1.
//  4. Read: we=0, s_addr=32'hDEAD -> state=STATE_C, last_wdata unchanged;
//     m_ready=1 -> m_valid=0, state=STATE_A next cycle.
//  5. Streaming 8 writes with m_ready=1 ->
//     - 8 downstream transfers in 8 consecutive cycles, in order.
//     - xfer_count=8.
//  6. Counter wrap: preload via 2^32-1 transfers (force) -> next accept gives
//     xfer_count=0.

Source files
------------

// File: rtl/test_pkg.sv
// Shared types for the bus bridge: transaction id width and the buffer-occupancy state encoding.
package test_pkg;

  localparam int WIDTH = 32;

  typedef logic [WIDTH-1:0] id_t;

  typedef enum logic [1:0] {
    STATE_A = 2'b00,  // empty
    STATE_B = 2'b01,  // holding a write
    STATE_C = 2'b10   // holding a read
  } state_t;

endpackage

// File: rtl/modport_hold_reg.sv
// Load-enable payload register with asynchronous active-high clear.
module modport_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/modport_bridge.sv
// One-entry registered valid/ready bridge: accepts an upstream transfer, holds it and
// re-issues it downstream, with a transfer counter and last-write-data debug status.
module modport_bridge
  import test_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_write_enable,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_write_enable,
  output logic [1:0]            state,
  output logic [31:0]           xfer_count,
  output logic [7:0]            last_wdata
);

  state_t state_reg, state_next;
  logic   m_valid_reg, m_valid_next;
  id_t    count_reg;
  logic [7:0] last_wdata_reg;
  logic   accept;
  logic   drain;

  // Draining and refilling in the same cycle keeps full throughput.
  assign s_ready = !m_valid_reg || m_ready;
  assign accept  = s_valid && s_ready;
  assign drain   = m_valid_reg && m_ready;

  modport_hold_reg #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .d   (s_addr),
    .q   (m_addr)
  );

  modport_hold_reg #(.WIDTH(DATA_WIDTH)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .d   (s_data),
    .q   (m_data)
  );

  modport_hold_reg #(.WIDTH(1)) u_we_reg (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .d   (s_write_enable),
    .q   (m_write_enable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= STATE_A;
      m_valid_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      m_valid_reg <= m_valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    m_valid_next = m_valid_reg;
    if (accept) begin
      m_valid_next = 1'b1;
    end else if (drain) begin
      m_valid_next = 1'b0;
    end
    case (state_reg)
      STATE_A: begin
        if (accept) begin
          state_next = s_write_enable ? STATE_B : STATE_C;
        end
      end
      STATE_B, STATE_C: begin
        if (accept) begin
          state_next = s_write_enable ? STATE_B : STATE_C;
        end else if (drain) begin
          state_next = STATE_A;
        end
      end
      default: state_next = STATE_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg      <= '0;
      last_wdata_reg <= '0;
    end else if (accept) begin
      count_reg <= count_reg + 1'b1;
      if (s_write_enable) begin
        last_wdata_reg <= s_data[7:0];
      end
    end
  end

  assign m_valid    = m_valid_reg;
  assign state      = state_reg;
  assign xfer_count = count_reg;
  assign last_wdata = last_wdata_reg;

endmodule

// File: tb/tb_modport_bridge.sv
// Scoreboard bench for modport_bridge: accepted requests queue their expected downstream
// transfer; a negedge monitor pops and compares on every downstream handshake.
module tb_modport_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
    logic        we;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [15:0] s_data;
  logic        s_write_enable;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [15:0] m_data;
  logic        m_write_enable;
  logic [1:0]  state;
  logic [31:0] xfer_count;
  logic [7:0]  last_wdata;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  xfer_t exp_q[$];
  int    done_q[$];

  modport_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_addr        (s_addr),
    .s_data        (s_data),
    .s_write_enable(s_write_enable),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_addr        (m_addr),
    .m_data        (m_data),
    .m_write_enable(m_write_enable),
    .state         (state),
    .xfer_count    (xfer_count),
    .last_wdata    (last_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Downstream monitor: every handshake must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got addr=%0h data=%0h we=%0b expected none",
                 m_addr, m_data, m_write_enable);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        check("downstream_xfer", {15'd0, m_addr, m_data, m_write_enable},
              {15'd0, e.addr, e.data, e.we});
      end
      done_q.push_back(cyc);
    end
  end

  // Called just after a posedge; returns just after the edge that accepted the request.
  task automatic send(input logic [31:0] a, input logic [15:0] d, input logic w);
    bit ok;
    xfer_t e;
    s_addr = a;
    s_data = d;
    s_write_enable = w;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    e.addr = a;
    e.data = d;
    e.we = w;
    exp_q.push_back(e);
    s_valid = 1'b0;
  endtask

  initial begin
    int start_cyc;
    rst = 1'b1;
    s_valid = 1'b0;
    s_addr = '0;
    s_data = '0;
    s_write_enable = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_state", state, 0);
    rst = 1'b0;

    // Reset mid-run discards a held transfer
    @(posedge clk); #1;
    send(32'h0000_0BAD, 16'hCAFE, 1'b1);
    check("pre_reset_m_valid", m_valid, 1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("rst_m_valid", m_valid, 0);
    check("rst_payload", {m_addr, m_data, m_write_enable}, 0);
    check("rst_state", state, 0);
    check("rst_count", xfer_count, 0);
    check("rst_last_wdata", last_wdata, 0);
    check("rst_s_ready", s_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write held under backpressure
    send(32'h10, 16'h1234, 1'b1);
    check("wr_m_valid", m_valid, 1);
    check("wr_m_addr", m_addr, 32'h10);
    check("wr_m_data", m_data, 16'h1234);
    check("wr_m_we", m_write_enable, 1);
    check("wr_state", state, 1);
    check("wr_last_wdata", last_wdata, 8'h34);
    check("wr_count", xfer_count, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_payload", {m_valid, m_addr, m_data}, {1'b1, 32'h10, 16'h1234});

    // Backpressure, then drain+accept on the same edge
    s_addr = 32'h20;
    s_data = 16'h5678;
    s_write_enable = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    check("bp_s_ready", s_ready, 0);
    @(posedge clk); #1;
    check("bp_count", xfer_count, 1);
    m_ready = 1'b1;
    @(negedge clk);
    check("drain_s_ready", s_ready, 1);
    @(posedge clk); #1;
    exp_q.push_back('{addr: 32'h20, data: 16'h5678, we: 1'b1});
    s_valid = 1'b0;
    check("b2b_m_valid", m_valid, 1);
    check("b2b_m_addr", m_addr, 32'h20);
    check("b2b_count", xfer_count, 2);
    check("b2b_last_wdata", last_wdata, 8'h78);
    @(posedge clk); #1;
    check("drained_m_valid", m_valid, 0);
    check("drained_state", state, 0);
    m_ready = 1'b0;

    // Read leaves last_wdata untouched
    send(32'hDEAD, 16'hBEEF, 1'b0);
    check("rd_state", state, 2);
    check("rd_last_wdata", last_wdata, 8'h78);
    check("rd_m_we", m_write_enable, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("rd_drained_m_valid", m_valid, 0);
    check("rd_drained_state", state, 0);

    // Streaming after a fresh reset
    rst = 1'b1;
    #1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    done_q.delete();
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      send(32'h100 + 32'(i), 16'hA000 + 16'(i), 1'b1);
    end
    check("stream_accept_cycles", cyc - start_cyc, 8);
    repeat (2) @(posedge clk);
    #1;
    check("stream_done_count", done_q.size(), 8);
    if (done_q.size() == 8) begin
      check("stream_done_span", done_q[7] - done_q[0], 7);
    end
    check("stream_count", xfer_count, 8);
    check("stream_last_wdata", last_wdata, 8'h07);

    // Counter wrap
    @(negedge clk);
    force dut.count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.count_reg;
    @(posedge clk); #1;
    send(32'h55, 16'h00C3, 1'b1);
    check("wrap_count", xfer_count, 0);
    check("wrap_last_wdata", last_wdata, 8'hC3);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
